// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - BIST sequencer for the LFSR/MISR pair; optional abort input via BIST_ABORT_EN
module bist_controller #(
    parameter int                N_PATTERNS = 7,
    parameter int                CNT_W      = 4,
    parameter int                SIG_W      = 3,
    parameter logic [SIG_W-1:0]  GOLDEN_P0  = 3'b101,
    parameter logic [SIG_W-1:0]  GOLDEN_P1  = 3'b011
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
`ifdef BIST_ABORT_EN
    input  logic             abort,
`endif
    input  logic [SIG_W-1:0] sig_in,
    output logic             lfsr_rst,
    output logic             lfsr_seed,
    output logic             lfsr_poly,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_poly
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             poly;
    logic             sig_bad;
    logic [1:0]       fail_next;
    logic             abort_hit;

    always_comb begin
        sig_bad = poly ? (sig_in != GOLDEN_P1) : (sig_in != GOLDEN_P0);
    end

    // Result vector as it will stand after the current CHECK cycle.
    always_comb begin
        fail_next       = fail_poly;
        fail_next[poly] = sig_bad;
    end

`ifdef BIST_ABORT_EN
    always_comb begin
        abort_hit = abort && (state == S_INIT || state == S_RUN || state == S_CHECK);
    end
`else
    always_comb begin
        abort_hit = 1'b0;
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            poly      <= 1'b0;
            lfsr_rst  <= 1'b1;
            lfsr_seed <= 1'b0;
            lfsr_poly <= 1'b0;
            misr_clr  <= 1'b0;
            misr_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_poly <= 2'b00;
        end else if (abort_hit) begin
            state     <= S_IDLE;
            cnt       <= '0;
            poly      <= 1'b0;
            lfsr_rst  <= 1'b1;
            lfsr_seed <= 1'b0;
            lfsr_poly <= 1'b0;
            misr_clr  <= 1'b0;
            misr_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_poly <= 2'b11;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_INIT;
                        cnt       <= '0;
                        poly      <= 1'b0;
                        pass      <= 1'b0;
                        fail_poly <= 2'b00;
                        lfsr_rst  <= 1'b0;
                        lfsr_seed <= 1'b1;
                        misr_clr  <= 1'b1;
                        lfsr_poly <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_INIT: begin
                    state     <= S_RUN;
                    cnt       <= '0;
                    lfsr_seed <= 1'b0;
                    misr_clr  <= 1'b0;
                    misr_en   <= 1'b1;
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state   <= S_CHECK;
                        misr_en <= 1'b0;
                    end
                end
                S_CHECK: begin
                    fail_poly <= fail_next;
                    if (!poly) begin
                        // Second pass with the other polynomial, reseeded and with a fresh MISR.
                        state     <= S_INIT;
                        poly      <= 1'b1;
                        cnt       <= '0;
                        lfsr_seed <= 1'b1;
                        misr_clr  <= 1'b1;
                        lfsr_poly <= 1'b1;
                    end else begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        lfsr_rst  <= 1'b1;
                        lfsr_poly <= 1'b0;
                        done      <= 1'b1;
                        pass      <= ~|fail_next;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    lfsr_rst <= 1'b1;
                    busy     <= 1'b0;
                    misr_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - directed self-checking bench for bist_controller
module tb_bist_controller;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       start = 1'b0;
`ifdef BIST_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic [2:0] sig_in = 3'b000;
    logic       lfsr_rst, lfsr_seed, lfsr_poly, misr_clr, misr_en, busy, done, pass;
    logic [1:0] fail_poly;
    logic [6:0] obs;

    int tests = 0;
    int fails = 0;

    bist_controller dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
`ifdef BIST_ABORT_EN
        .abort     (abort),
`endif
        .sig_in    (sig_in),
        .lfsr_rst  (lfsr_rst),
        .lfsr_seed (lfsr_seed),
        .lfsr_poly (lfsr_poly),
        .misr_clr  (misr_clr),
        .misr_en   (misr_en),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_poly (fail_poly)
    );

    always #5 CLK = ~CLK;

    assign obs = {busy, lfsr_rst, lfsr_seed, misr_clr, misr_en, lfsr_poly, done};

    // Expected {busy,lfsr_rst,lfsr_seed,misr_clr,misr_en,lfsr_poly,done} in cycle c after start.
    function automatic logic [6:0] exp_vec(input int c);
        if (c == 1)                 return 7'b1011000;
        else if (c >= 2 && c <= 8)  return 7'b1000100;
        else if (c == 9)            return 7'b1000000;
        else if (c == 10)           return 7'b1011010;
        else if (c >= 11 && c <= 17) return 7'b1000110;
        else if (c == 18)           return 7'b1000010;
        else if (c == 19)           return 7'b0100001;
        else                        return 7'b0100000;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_run;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        tick();
        tick();
        tests++;
        if (obs !== 7'b0100000) begin
            fails++;
            $display("FAIL reset_outputs got %b exp %b", obs, 7'b0100000);
        end
        tests++;
        if (pass !== 1'b0 || fail_poly !== 2'b00) begin
            fails++;
            $display("FAIL reset_result got pass=%b fail_poly=%b exp pass=0 fail_poly=00", pass, fail_poly);
        end
        RST = 1'b1;
        tick();
        tests++;
        if (obs !== 7'b0100000) begin
            fails++;
            $display("FAIL idle_after_reset got %b exp %b", obs, 7'b0100000);
        end
    endtask

    task automatic test_pass_run;
        int en_cnt = 0;
        int seed_cnt = 0;
        sig_in = 3'b101;
        start_run();
        for (int c = 1; c <= 20; c++) begin
            tests++;
            if (obs !== exp_vec(c)) begin
                fails++;
                $display("FAIL pass_trace c=%0d got %b exp %b", c, obs, exp_vec(c));
            end
            en_cnt   += int'(misr_en);
            seed_cnt += int'(lfsr_seed);
            if (c == 19) begin
                tests++;
                if (pass !== 1'b1 || fail_poly !== 2'b00) begin
                    fails++;
                    $display("FAIL pass_result got pass=%b fail_poly=%b exp pass=1 fail_poly=00", pass, fail_poly);
                end
            end
            if (c == 10) sig_in = 3'b011;
            tick();
        end
        tests++;
        if (en_cnt != 14) begin
            fails++;
            $display("FAIL misr_en_cycles got %0d exp 14", en_cnt);
        end
        tests++;
        if (seed_cnt != 2) begin
            fails++;
            $display("FAIL seed_cycles got %0d exp 2", seed_cnt);
        end
        tick();
        tests++;
        if (pass !== 1'b1 || fail_poly !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL pass_hold got pass=%b fail_poly=%b busy=%b exp 1 00 0", pass, fail_poly, busy);
        end
    endtask

    task automatic test_fail_poly0;
        sig_in = 3'b100;
        start_run();
        for (int c = 1; c <= 19; c++) begin
            if (c == 10) sig_in = 3'b011;
            if (c == 18) begin
                tests++;
                if (busy !== 1'b1 || lfsr_poly !== 1'b1) begin
                    fails++;
                    $display("FAIL poly1_runs got busy=%b lfsr_poly=%b exp 1 1", busy, lfsr_poly);
                end
            end
            if (c == 19) begin
                tests++;
                if (done !== 1'b1 || pass !== 1'b0 || fail_poly !== 2'b01) begin
                    fails++;
                    $display("FAIL fail_p0_result got done=%b pass=%b fail_poly=%b exp 1 0 01", done, pass, fail_poly);
                end
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset_midrun;
        int done_seen = 0;
        sig_in = 3'b000;
        start_run();
        for (int c = 1; c <= 12; c++) tick();
        tests++;
        if (obs !== exp_vec(13) || fail_poly !== 2'b01) begin
            fails++;
            $display("FAIL midrun_pre got %b fail_poly=%b exp %b 01", obs, fail_poly, exp_vec(13));
        end
        RST = 1'b0;
        tick();
        tests++;
        if (obs !== 7'b0100000 || pass !== 1'b0 || fail_poly !== 2'b00) begin
            fails++;
            $display("FAIL midrun_reset got %b pass=%b fail_poly=%b exp 0100000 0 00", obs, pass, fail_poly);
        end
        RST = 1'b1;
        for (int c = 0; c < 25; c++) begin
            done_seen += int'(done | busy);
            tick();
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL midrun_no_done got %0d active cycles exp 0", done_seen);
        end
    endtask

    task automatic test_back_to_back;
        int busy_after = 0;
        sig_in = 3'b101;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 40; c++) begin
            if (c == 10 || c == 30) sig_in = 3'b011;
            if (c == 20) sig_in = 3'b101;
            if (c == 19 || c == 39) begin
                tests++;
                if (done !== 1'b1 || pass !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_done c=%0d got done=%b pass=%b exp 1 1", c, done, pass);
                end
            end
            if (c == 20) begin
                tests++;
                if (obs !== 7'b0100000) begin
                    fails++;
                    $display("FAIL b2b_idle got %b exp 0100000", obs);
                end
            end
            if (c == 21) begin
                tests++;
                if (obs !== exp_vec(1)) begin
                    fails++;
                    $display("FAIL b2b_restart got %b exp %b", obs, exp_vec(1));
                end
                start = 1'b0;
            end
            tick();
        end
        sig_in = 3'b101;
        start_run();
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            if (c == 10) sig_in = 3'b011;
            if (c == 19) begin
                tests++;
                if (done !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_start_done got done=%b exp 1", done);
                end
            end
            if (c >= 20) busy_after += int'(busy);
            tick();
        end
        tests++;
        if (busy_after != 0) begin
            fails++;
            $display("FAIL busy_start_ignored got %0d busy cycles exp 0", busy_after);
        end
    endtask

`ifdef BIST_ABORT_EN
    task automatic test_abort;
        int done_seen = 0;
        sig_in = 3'b101;
        start_run();
        for (int c = 1; c <= 3; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if (obs !== 7'b0100000 || pass !== 1'b0 || fail_poly !== 2'b11) begin
            fails++;
            $display("FAIL abort_state got %b pass=%b fail_poly=%b exp 0100000 0 11", obs, pass, fail_poly);
        end
        for (int c = 0; c < 25; c++) begin
            done_seen += int'(done | busy);
            tick();
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL abort_no_done got %0d active cycles exp 0", done_seen);
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_pass_run();
        test_fail_poly0();
        test_reset_midrun();
        test_back_to_back();
`ifdef BIST_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
